// File: rtl/pmem_responder.sv
`timescale 1ns/1ps
// pmem_responder
// Line-granular physical-memory responder for the L2 / eviction-write-buffer
// memory port. It serves one 128-bit line read or write at a time and answers
// with a one-cycle pmem_resp pulse after a fixed service delay. The backing
// array is never cleared; only the control state and the status outputs reset.
//
// Ports
//   clk            single rising-edge clock
//   reset          asynchronous, active-high reset
//   pmem_read      line read request, held until pmem_resp
//   pmem_write     line write request, held until pmem_resp
//   pmem_address   byte address; line index = pmem_address[4+LINE_IDX_BITS-1:4]
//   pmem_wdata     write line
//   pmem_rdata     last line read; valid while pmem_resp is high for a read
//   pmem_resp      one-cycle completion pulse
//   busy           high while a transaction is in service or responding
//   protocol_error sticky flag, set when read and write arrive together
//   read_count     completed reads, saturating at 0xFFFF
//   write_count    completed writes, saturating at 0xFFFF
module pmem_responder #(
  parameter int DELAY         = 10,
  parameter int LINE_IDX_BITS = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         busy,
  output logic         protocol_error,
  output logic [15:0]  read_count,
  output logic [15:0]  write_count
);

  localparam int CNT_W = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DELAY - 1);
  localparam int LINES = 1 << LINE_IDX_BITS;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0]         cnt;
  logic [LINE_IDX_BITS-1:0] idx_q;
  logic [127:0]             wdata_q;
  logic                     op_write_q;

  logic latch_req;
  logic commit;
  logic cnt_zero;

  logic [127:0] mem [LINES];

  // Only the index bits select a line; the byte offset and any bits above the
  // index are deliberately ignored so aliased addresses hit the same line.
  logic unused_addr_bits;
  assign unused_addr_bits = ^pmem_address;

  assign cnt_zero = (cnt == '0);

  // State register; reset aborts whatever transaction is in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and outputs. RESP always returns to IDLE without sampling,
  // which is what forces at least one idle cycle between transactions.
  always_comb begin
    state_next = state;
    pmem_resp  = 1'b0;
    busy       = 1'b0;
    latch_req  = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (pmem_read || pmem_write) begin
          latch_req  = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        busy = 1'b1;
        if (cnt_zero) begin
          commit     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        busy       = 1'b1;
        pmem_resp  = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request capture, delay counter, read data and status. Everything after
  // the capture edge works from the latched copies so the requester may
  // drop or change its request while the transaction is in service.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt            <= '0;
      idx_q          <= '0;
      wdata_q        <= '0;
      op_write_q     <= 1'b0;
      pmem_rdata     <= '0;
      protocol_error <= 1'b0;
      read_count     <= '0;
      write_count    <= '0;
    end else begin
      if (latch_req) begin
        idx_q      <= pmem_address[4+LINE_IDX_BITS-1:4];
        wdata_q    <= pmem_wdata;
        op_write_q <= pmem_write;
        cnt        <= CNT_LOAD;
        if (pmem_read && pmem_write) begin
          protocol_error <= 1'b1;
        end
      end else if (state == BUSY && !cnt_zero) begin
        cnt <= cnt - 1'b1;
      end

      if (commit) begin
        if (op_write_q) begin
          if (write_count != 16'hFFFF) begin
            write_count <= write_count + 16'd1;
          end
        end else begin
          pmem_rdata <= mem[idx_q];
          if (read_count != 16'hFFFF) begin
            read_count <= read_count + 16'd1;
          end
        end
      end
    end
  end

  // Backing array, deliberately outside the reset domain. A write lands on
  // the same edge that enters RESP, so a read issued right after sees it.
  always_ff @(posedge clk) begin
    if (commit && op_write_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule
